// File: rtl/cfi_log_queue_if.sv
// Shared CFI log/exception types and the monitor-side handshake interface.
// The queue drives the master side; the CFI monitor sits on the slave side.
package cfi_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic [1:0]  kind;
  } cfi_commit_log_t;

  typedef struct packed {
    logic [31:0] cause;
    logic [31:0] tval;
    logic        valid;
  } exception_t;

  localparam logic [31:0] CFI_FAULT_CAUSE = 32'd18;
endpackage

interface cfi_mon_if;
  logic                     mon_valid_o;
  cfi_pkg::cfi_commit_log_t mon_log_o;
  logic                     mon_ready_i;
  logic                     resp_valid_i;
  logic                     resp_fault_i;

  modport master (
    output mon_valid_o, mon_log_o,
    input  mon_ready_i, resp_valid_i, resp_fault_i
  );

  modport slave (
    input  mon_valid_o, mon_log_o,
    output mon_ready_i, resp_valid_i, resp_fault_i
  );
endinterface

// File: rtl/cfi_log_queue.sv
// Commit-side CFI log queue feeding one-at-a-time monitor checks.
// Define CFI_QUEUE_STATS_EN to enable the sent-log counter.
module cfi_log_queue
  import cfi_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned DEPTH           = 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  cfi_commit_log_t [NR_COMMIT_PORTS-1:0] log_i,
  input  logic [NR_COMMIT_PORTS-1:0]            log_valid_i,
  input  logic                                  flush_i,
  cfi_mon_if.master                             mon,
  output logic                                  cfi_wait_o,
  output exception_t                            cfi_fault_o,
  output logic                                  overflow_o,
  output logic [31:0]                           sent_cnt_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);
  localparam logic [CW-1:0] NR_W    = CW'(NR_COMMIT_PORTS);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_RESP,
    FAULT
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  cfi_commit_log_t mem_q [DEPTH];
  cfi_commit_log_t mem_d [DEPTH];
  logic            ovf_q, ovf_d;
  logic [31:0]     pc_q, pc_d;
  logic            pend_q, pend_d;

  logic [CW-1:0]   free;
  logic [CW-1:0]   pushes;
  logic            pop;

  assign free = DEPTH_W - count_q;

  always_comb begin
    mem_d           = mem_q;
    head_d          = head_q;
    tail_d          = tail_q;
    ovf_d           = ovf_q;
    pc_d            = pc_q;
    pend_d          = 1'b0;
    state_d         = state_q;
    pushes          = '0;
    pop             = 1'b0;
    mon.mon_valid_o = 1'b0;
    mon.mon_log_o   = mem_q[head_q];

    // Ports pack densely from the tail; whatever no longer fits is dropped.
    for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
      if (log_valid_i[i]) begin
        if (pushes < free) begin
          mem_d[tail_q + pushes[PW-1:0]] = log_i[i];
          pushes = pushes + CW'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
    tail_d = tail_q + pushes[PW-1:0];

    unique case (state_q)
      IDLE: begin
        if (count_q != '0) state_d = SEND;
      end
      SEND: begin
        mon.mon_valid_o = 1'b1;
        if (mon.mon_ready_i) begin
          pop     = 1'b1;
          head_d  = head_q + PW'(1);
          pc_d    = mem_q[head_q].pc;
          state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (mon.resp_valid_i) begin
          if (mon.resp_fault_i) begin
            state_d = FAULT;
            pend_d  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: state_d = IDLE;
    endcase

    count_d = count_q + pushes - CW'(pop);

    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      pend_d  = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      pc_q    <= '0;
      pend_q  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      mem_q   <= mem_d;
    end
  end

  assign cfi_wait_o        = (free < NR_W) || (state_q == FAULT);
  assign overflow_o        = ovf_q;
  assign cfi_fault_o.valid = pend_q && (state_q == FAULT);
  assign cfi_fault_o.cause = cfi_fault_o.valid ? CFI_FAULT_CAUSE : '0;
  assign cfi_fault_o.tval  = cfi_fault_o.valid ? pc_q : '0;

`ifdef CFI_QUEUE_STATS_EN
  logic [31:0] sent_q, sent_d;

  assign sent_d = sent_q + {31'b0, mon.mon_valid_o & mon.mon_ready_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sent_q <= '0;
    else         sent_q <= sent_d;
  end

  assign sent_cnt_o = sent_q;
`else
  assign sent_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cfi_log_queue.sv
// Directed self-checking bench for cfi_log_queue (NR_COMMIT_PORTS=2, DEPTH=8).
module tb_cfi_log_queue;
  import cfi_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  cfi_commit_log_t [1:0] log_i;
  logic [1:0]            log_valid;
  logic                  flush;
  logic                  cfi_wait;
  exception_t            fault;
  logic                  ovf;
  logic [31:0]           sent;

  int checks = 0;
  int errors = 0;

`ifdef CFI_QUEUE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  cfi_mon_if mon ();

  cfi_log_queue #(
    .NR_COMMIT_PORTS(2),
    .DEPTH          (8)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .log_i      (log_i),
    .log_valid_i(log_valid),
    .flush_i    (flush),
    .mon        (mon),
    .cfi_wait_o (cfi_wait),
    .cfi_fault_o(fault),
    .overflow_o (ovf),
    .sent_cnt_o (sent)
  );

  always #5 clk = ~clk;

  function automatic cfi_commit_log_t mk(logic [31:0] pc);
    cfi_commit_log_t l;
    l.pc     = pc;
    l.target = pc + 32'h100;
    l.kind   = 2'd1;
    return l;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n            = 1'b0;
    log_valid        = '0;
    log_i            = '0;
    flush            = 1'b0;
    mon.mon_ready_i  = 1'b0;
    mon.resp_valid_i = 1'b0;
    mon.resp_fault_i = 1'b0;
    step;
    step;
    rst_n = 1'b1;
  endtask

  task automatic wait_mon(input int limit);
    int t = 0;
    while (!mon.mon_valid_o && t < limit) begin
      step;
      t++;
    end
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (mon.mon_valid_o !== 1'b0) begin errors++; $display("FAIL rst_mon_valid got %b want 0", mon.mon_valid_o); end
    checks++; if (cfi_wait !== 1'b0) begin errors++; $display("FAIL rst_wait got %b want 0", cfi_wait); end
    checks++; if (fault !== '0) begin errors++; $display("FAIL rst_fault got %h want 0", fault); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", ovf); end
    checks++; if (sent !== 32'd0) begin errors++; $display("FAIL rst_sent got %0d want 0", sent); end
    checks++; if (dut.count_q !== 4'd0) begin errors++; $display("FAIL rst_count got %0d want 0", dut.count_q); end
  endtask

  task automatic test_order;
    logic [31:0] got [6];
    int n = 0;
    bit bad_fault = 1'b0;
    do_reset;
    mon.mon_ready_i  = 1'b1;
    mon.resp_valid_i = 1'b1;
    mon.resp_fault_i = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (c < 3) begin
        log_valid = 2'b11;
        log_i[0]  = mk(32'h1000 + 32'(c * 8));
        log_i[1]  = mk(32'h1004 + 32'(c * 8));
      end else begin
        log_valid = 2'b00;
      end
      if (mon.mon_valid_o) begin
        if (n < 6) got[n] = mon.mon_log_o.pc;
        n++;
      end
      if (fault.valid) bad_fault = 1'b1;
      step;
    end
    mon.mon_ready_i  = 1'b0;
    mon.resp_valid_i = 1'b0;
    checks++; if (n !== 6) begin errors++; $display("FAIL order_count got %0d want 6", n); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (k < n && got[k] !== 32'h1000 + 32'(k * 4)) begin
        errors++;
        $display("FAIL order_pc%0d got %h want %h", k, got[k], 32'h1000 + 32'(k * 4));
      end
    end
    checks++; if (bad_fault !== 1'b0) begin errors++; $display("FAIL order_nofault got %b want 0", bad_fault); end
    checks++; if (sent !== (STATS ? 32'd6 : 32'd0)) begin errors++; $display("FAIL order_sent got %0d want %0d", sent, STATS ? 6 : 0); end
  endtask

  task automatic test_overflow;
    do_reset;
    for (int c = 0; c < 3; c++) begin
      log_valid = 2'b11;
      log_i[0]  = mk(32'h2000 + 32'(c * 8));
      log_i[1]  = mk(32'h2004 + 32'(c * 8));
      step;
    end
    log_valid = 2'b00;
    checks++; if (dut.count_q !== 4'd6) begin errors++; $display("FAIL ovf_count6 got %0d want 6", dut.count_q); end
    checks++; if (cfi_wait !== 1'b0) begin errors++; $display("FAIL ovf_wait6 got %b want 0", cfi_wait); end
    log_valid = 2'b01;
    log_i[0]  = mk(32'h2018);
    step;
    log_valid = 2'b00;
    checks++; if (dut.count_q !== 4'd7) begin errors++; $display("FAIL ovf_count7 got %0d want 7", dut.count_q); end
    checks++; if (cfi_wait !== 1'b1) begin errors++; $display("FAIL ovf_wait7 got %b want 1", cfi_wait); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", ovf); end
    log_valid = 2'b11;
    log_i[0]  = mk(32'h201c);
    log_i[1]  = mk(32'h2020);
    step;
    log_valid = 2'b00;
    checks++; if (dut.count_q !== 4'd8) begin errors++; $display("FAIL ovf_count8 got %0d want 8", dut.count_q); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", ovf); end
    checks++; if (dut.mem_q[7].pc !== 32'h201c) begin errors++; $display("FAIL ovf_kept got %h want 201c", dut.mem_q[7].pc); end
    checks++; if (mon.mon_valid_o !== 1'b1) begin errors++; $display("FAIL ovf_mon_valid got %b want 1", mon.mon_valid_o); end
    step;
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", ovf); end
    checks++; if (mon.mon_log_o.pc !== 32'h2000) begin errors++; $display("FAIL ovf_head_stable got %h want 2000", mon.mon_log_o.pc); end
    flush = 1'b1;
    step;
    flush = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_flush got %b want 0", ovf); end
    checks++; if (dut.count_q !== 4'd0) begin errors++; $display("FAIL ovf_flush_count got %0d want 0", dut.count_q); end
    checks++; if (cfi_wait !== 1'b0) begin errors++; $display("FAIL ovf_flush_wait got %b want 0", cfi_wait); end
  endtask

  task automatic test_fault;
    do_reset;
    mon.resp_valid_i = 1'b1;
    mon.resp_fault_i = 1'b1;
    log_valid = 2'b01;
    log_i[0]  = mk(32'h8000_0040);
    step;
    log_valid = 2'b00;
    wait_mon(10);
    checks++; if (mon.mon_valid_o !== 1'b1) begin errors++; $display("FAIL flt_send got %b want 1", mon.mon_valid_o); end
    checks++; if (mon.mon_log_o.pc !== 32'h8000_0040) begin errors++; $display("FAIL flt_pc got %h want 80000040", mon.mon_log_o.pc); end
    checks++; if (fault.valid !== 1'b0 || cfi_wait !== 1'b0) begin errors++; $display("FAIL flt_resp_ignored got v=%b w=%b want 0 0", fault.valid, cfi_wait); end
    mon.mon_ready_i = 1'b1;
    step;
    mon.mon_ready_i = 1'b0;
    checks++; if (mon.mon_valid_o !== 1'b0 || fault.valid !== 1'b0) begin errors++; $display("FAIL flt_wait_resp got mv=%b fv=%b want 0 0", mon.mon_valid_o, fault.valid); end
    step;
    mon.resp_valid_i = 1'b0;
    checks++; if (fault.valid !== 1'b1) begin errors++; $display("FAIL flt_valid got %b want 1", fault.valid); end
    checks++; if (fault.cause !== 32'd18) begin errors++; $display("FAIL flt_cause got %0d want 18", fault.cause); end
    checks++; if (fault.tval !== 32'h8000_0040) begin errors++; $display("FAIL flt_tval got %h want 80000040", fault.tval); end
    checks++; if (cfi_wait !== 1'b1) begin errors++; $display("FAIL flt_wait got %b want 1", cfi_wait); end
    step;
    checks++; if (fault !== '0) begin errors++; $display("FAIL flt_one_cycle got %h want 0", fault); end
    step;
    step;
    checks++; if (cfi_wait !== 1'b1) begin errors++; $display("FAIL flt_wait_held got %b want 1", cfi_wait); end
    flush = 1'b1;
    step;
    flush = 1'b0;
    checks++; if (cfi_wait !== 1'b0 || fault.valid !== 1'b0) begin errors++; $display("FAIL flt_flush got w=%b v=%b want 0 0", cfi_wait, fault.valid); end
  endtask

  task automatic test_concurrent;
    do_reset;
    log_valid = 2'b11;
    log_i[0]  = mk(32'h3000);
    log_i[1]  = mk(32'h3004);
    step;
    log_valid = 2'b01;
    log_i[0]  = mk(32'h3008);
    step;
    log_valid = 2'b00;
    checks++; if (dut.count_q !== 4'd3 || mon.mon_valid_o !== 1'b1) begin errors++; $display("FAIL conc_pre got c=%0d mv=%b want 3 1", dut.count_q, mon.mon_valid_o); end
    mon.mon_ready_i = 1'b1;
    log_valid = 2'b01;
    log_i[0]  = mk(32'h300c);
    step;
    mon.mon_ready_i = 1'b0;
    log_valid = 2'b00;
    checks++; if (dut.count_q !== 4'd3) begin errors++; $display("FAIL conc_count got %0d want 3", dut.count_q); end
    checks++; if (mon.mon_valid_o !== 1'b0) begin errors++; $display("FAIL conc_popped got %b want 0", mon.mon_valid_o); end
  endtask

  task automatic test_reset_flush;
    do_reset;
    log_valid = 2'b01;
    log_i[0]  = mk(32'h4000);
    step;
    log_valid = 2'b00;
    wait_mon(10);
    checks++; if (mon.mon_valid_o !== 1'b1) begin errors++; $display("FAIL rf_send got %b want 1", mon.mon_valid_o); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (mon.mon_valid_o !== 1'b0) begin errors++; $display("FAIL rf_async_mv got %b want 0", mon.mon_valid_o); end
    checks++; if (dut.count_q !== 4'd0) begin errors++; $display("FAIL rf_async_count got %0d want 0", dut.count_q); end
    step;
    rst_n = 1'b1;
    log_valid = 2'b11;
    log_i[0]  = mk(32'h4010);
    log_i[1]  = mk(32'h4014);
    flush     = 1'b1;
    step;
    log_valid = 2'b00;
    flush     = 1'b0;
    checks++; if (dut.count_q !== 4'd0) begin errors++; $display("FAIL rf_flush_push got %0d want 0", dut.count_q); end
    step;
    checks++; if (mon.mon_valid_o !== 1'b0) begin errors++; $display("FAIL rf_idle got %b want 0", mon.mon_valid_o); end
  endtask

  task automatic test_stats;
    do_reset;
    mon.mon_ready_i  = 1'b1;
    mon.resp_valid_i = 1'b1;
    mon.resp_fault_i = 1'b0;
    for (int c = 0; c < 40; c++) begin
      log_valid = (c < 2) ? 2'b11 : (c == 2) ? 2'b01 : 2'b00;
      log_i[0]  = mk(32'h5000 + 32'(c * 8));
      log_i[1]  = mk(32'h5004 + 32'(c * 8));
      step;
    end
    log_valid        = 2'b00;
    mon.mon_ready_i  = 1'b0;
    mon.resp_valid_i = 1'b0;
    checks++; if (sent !== (STATS ? 32'd5 : 32'd0)) begin errors++; $display("FAIL stats_sent got %0d want %0d", sent, STATS ? 5 : 0); end
  endtask

  initial begin
    test_reset;
    test_order;
    test_overflow;
    test_fault;
    test_concurrent;
    test_reset_flush;
    test_stats;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cfi_log_queue.md
CFI_LOG_QUEUE -- requirements
Module: cfi_log_queue

Interface
REQ-001 SHALL have parameter NR_COMMIT_PORTS, default 2: number of commit ports scanned per cycle.
REQ-002 SHALL have parameter DEPTH, default 8: queue entries; power of two, >= NR_COMMIT_PORTS.
REQ-003 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-005 SHALL have port log_i  input  NR_COMMIT_PORTS x cfi_commit_log_t  per-port commit log from the scanners.
REQ-006 SHALL have port log_valid_i  input  NR_COMMIT_PORTS  per-port: committed (ack) control-flow instruction present.
REQ-007 SHALL have port flush_i  input  1  clears queue and fault state.
REQ-008 SHALL have port mon_valid_o  output  1  head log offered to the CFI monitor.
REQ-009 SHALL have port mon_log_o  output  cfi_commit_log_t  head log.
REQ-010 SHALL have port mon_ready_i  input  1  monitor accepts head log.
REQ-011 SHALL have port resp_valid_i  input  1  monitor verdict valid.
REQ-012 SHALL have port resp_fault_i  input  1  verdict: 1 = violation.
REQ-013 SHALL have port cfi_wait_o  output  1  stall commit.
REQ-014 SHALL have port cfi_fault_o  output  exception_t  CFI exception to commit.
REQ-015 SHALL have port overflow_o  output  1  sticky: log dropped.
REQ-016 SHALL have port sent_cnt_o  output  32  logs accepted by monitor.

Function
REQ-017 Enqueue: SHALL write valid ports in ascending port order into consecutive entries at tail, same cycle; tail advances by popcount(log_valid_i).
REQ-018 Occupancy SHALL be count after simultaneous enqueue and dequeue (count + pushes - pop); pointers wrap modulo DEPTH.
REQ-019 cfi_wait_o SHALL be combinational: 1 when free entries < NR_COMMIT_PORTS, or FSM in FAULT.
REQ-020 Push when free < popcount(log_valid_i): SHALL store only entries fitting, drop rest, set overflow_o until flush_i or reset.
REQ-021 FSM states IDLE, SEND, WAIT_RESP, FAULT.
REQ-022 IDLE -> SEND when count != 0 (next cycle); mon_valid_o = 1 only in SEND, mon_log_o = head entry.
REQ-023 SEND: mon_valid_o and mon_log_o SHALL stay stable until mon_ready_i; on handshake pop head, go WAIT_RESP.
REQ-024 WAIT_RESP: on resp_valid_i with resp_fault_i=0 go IDLE; with resp_fault_i=1 go FAULT, latch popped log's pc.
REQ-025 Only one log outstanding; resp_valid_i outside WAIT_RESP SHALL be ignored.
REQ-026 FAULT: cfi_fault_o.valid = 1 for exactly first FAULT cycle, cause = cfi_pkg::CFI_FAULT_CAUSE, tval = latched pc; state held (wait high) until flush_i.
REQ-027 cfi_fault_o.valid SHALL be 0 in all other states; cause/tval 0 when not valid.
REQ-028 flush_i SHALL empty queue, clear overflow_o, force IDLE next cycle; flush wins over same-cycle push, handshake and response.

Reset
REQ-029 On rst_ni low, immediately: pointers/count 0, FSM IDLE, mon_valid_o 0, cfi_wait_o 0, cfi_fault_o all 0, overflow_o 0, sent_cnt_o 0; any in-flight handshake abandoned.

Configuration
REQ-030 Macro CFI_QUEUE_STATS_EN defined: sent_cnt_o increments on each mon_valid_o & mon_ready_i, wraps at 2^32, not cleared by flush_i.
REQ-031 Macro CFI_QUEUE_STATS_EN undefined: sent_cnt_o tied 0, no counter logic.

Verification
REQ-032 Both ports valid, mon_ready_i=1, resp ok each cycle -> logs reach mon_log_o in port-0, port-1 order; no fault.
REQ-033 Push 2/cycle, mon_ready_i=0, DEPTH=8 -> cfi_wait_o rises when count=7; push 2 at count 7 -> 1 stored, overflow_o=1.
REQ-034 Log pc=0x8000_0040 sent, resp_fault_i=1 -> next cycle cfi_fault_o.valid=1 one cycle, tval=0x8000_0040; cfi_wait_o held until flush_i.
REQ-035 Push and handshake same cycle at count=3 -> count stays 3.
REQ-036 rst_ni low during SEND -> mon_valid_o 0 immediately, queue empty; flush_i with push same cycle -> count 0.
REQ-037 With CFI_QUEUE_STATS_EN, 5 handshakes -> sent_cnt_o=5; without -> 0.
